// File: rtl/uart_frame_rx.sv
// uart_frame_rx
//   Serial receive front end: synchronises the raw RX pin, decodes 8N1
//   characters by mid-bit sampling and packs FRAME_BYTES characters into one
//   wide word, announced by a single-cycle valid strobe.
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   uart_rx      raw serial line, idle high
//   data         last complete frame; first received byte in the top byte
//   valid        one-cycle pulse in the cycle data updates
//   framing_err  one-cycle pulse on a bad (low) stop bit
module uart_frame_rx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int FRAME_BYTES  = 11,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     uart_rx,
   output logic [8*FRAME_BYTES-1:0] data,
   output logic                     valid,
   output logic                     framing_err
);

   localparam int CW       = $clog2(CLKS_PER_BIT);
   localparam int BW       = $clog2(FRAME_BYTES + 1);
   localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int IW       = $clog2(TO_LIMIT + 1);

   localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_BYTES - 1);
   localparam logic [IW-1:0] TO_CNT   = IW'(TO_LIMIT);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t                   state, state_nxt;
   logic [1:0]               sync;
   logic                     rxs;
   logic [CW-1:0]            clk_cnt;
   logic [2:0]               bit_idx;
   logic [7:0]               shift;
   logic [8*FRAME_BYTES-1:0] frame_buf;
   logic [BW-1:0]            byte_cnt;
   logic [IW-1:0]            idle_cnt;
   logic                     frame_pend;

   logic cnt_hit, cnt_clr, start_go, data_smp, accept, stop_bad, to_hit;

   assign rxs = sync[1];

   // Next-state and per-cycle strobes
   always_comb begin
      state_nxt = state;
      cnt_hit   = 1'b0;
      cnt_clr   = 1'b1;
      case (state)
         IDLE: begin
            if (!rxs) state_nxt = START;
         end
         START: begin
            cnt_hit = (clk_cnt == HALF_M1);
            cnt_clr = cnt_hit;
            // a start bit that is gone by mid-bit was a glitch
            if (cnt_hit) state_nxt = rxs ? IDLE : DATA;
         end
         DATA: begin
            cnt_hit = (clk_cnt == FULL_M1);
            cnt_clr = cnt_hit;
            if (cnt_hit && bit_idx == 3'd7) state_nxt = STOP;
         end
         STOP: begin
            cnt_hit = (clk_cnt == FULL_M1);
            cnt_clr = cnt_hit;
            // leave mid stop bit so a back-to-back start edge is not missed
            if (cnt_hit) state_nxt = rxs ? IDLE : WAIT_HIGH;
         end
         WAIT_HIGH: begin
            if (rxs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign start_go = (state == IDLE) && !rxs;
   assign data_smp = (state == DATA) && cnt_hit;
   assign accept   = (state == STOP) && cnt_hit && rxs;
   assign stop_bad = (state == STOP) && cnt_hit && !rxs;
   assign to_hit   = (state == IDLE) && (byte_cnt != '0) && (idle_cnt == TO_CNT);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync        <= 2'b11;
         state       <= IDLE;
         clk_cnt     <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         frame_buf   <= '0;
         byte_cnt    <= '0;
         idle_cnt    <= '0;
         frame_pend  <= 1'b0;
         data        <= '0;
         valid       <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         sync        <= {sync[0], uart_rx};
         state       <= state_nxt;
         valid       <= 1'b0;
         framing_err <= 1'b0;
         frame_pend  <= 1'b0;

         clk_cnt <= cnt_clr ? '0 : clk_cnt + CW'(1);

         if (start_go) begin
            bit_idx <= '0;
         end else if (data_smp) begin
            shift   <= {rxs, shift[7:1]};  // LSB arrives first
            bit_idx <= (bit_idx == 3'd7) ? 3'd0 : bit_idx + 3'd1;
         end

         // Byte count: completion, accept, error and timeout are mutually
         // exclusive in time except completion vs. timeout, where completion
         // clears the count anyway.
         if (frame_pend) begin
            data     <= frame_buf;
            valid    <= 1'b1;
            byte_cnt <= '0;
         end else if (accept) begin
            frame_buf  <= {frame_buf[8*FRAME_BYTES-9:0], shift};
            byte_cnt   <= byte_cnt + BW'(1);
            frame_pend <= (byte_cnt == LAST_IDX);
         end else if (stop_bad) begin
            framing_err <= 1'b1;
            byte_cnt    <= '0;
         end else if (to_hit) begin
            byte_cnt <= '0;
         end

         // Idle timer only runs while a partial frame is held; a start edge
         // restarts it even if it coincides with expiry.
         if (start_go)
            idle_cnt <= '0;
         else if (to_hit)
            idle_cnt <= '0;
         else if (state == IDLE && byte_cnt != '0)
            idle_cnt <= idle_cnt + IW'(1);
      end
   end

endmodule
